// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_LDR = 1;

    // Wide enough for the largest legal burst limit (15).
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_arb_burst_cnt.sv
// Saturating beat counter for the current memory owner.
// Flags the cycle in which the owner is on its last allowed beat.
module dmem_arb_burst_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counts completed beats, so the beat in flight is the last one once this is reached.
    assign at_limit = (cnt_q >= LastCnt);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / loader) arbiter in front of a single-ported data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to port 0.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              stall0,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    arb_state_e state_q, state_d;

    logic [1:0]        req_v;
    logic [1:0]        gnt_v;
    logic [1:0]        beat_v;
    logic              at_limit;
    logic              tie_to_ldr;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    assign req_v = {req1, req0};
    assign gnt_v[PORT_CPU] = (state_q == OWN0);
    assign gnt_v[PORT_LDR] = (state_q == OWN1);
    assign beat_v = gnt_v & req_v;

`ifdef ARB_ROUND_ROBIN_EN
    // Most recent winner; resets to the loader so the CPU wins the first tie.
    logic last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state_d != IDLE) begin
            last_q <= (state_d == OWN1);
        end
    end

    assign tie_to_ldr = ~last_q;
`else
    assign tie_to_ldr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_v[PORT_CPU] && req_v[PORT_LDR]) begin
                    state_d = tie_to_ldr ? OWN1 : OWN0;
                end else if (req_v[PORT_CPU]) begin
                    state_d = OWN0;
                end else if (req_v[PORT_LDR]) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req_v[PORT_CPU]) begin
                    state_d = req_v[PORT_LDR] ? OWN1 : IDLE;
                end else if (req_v[PORT_LDR] && at_limit) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req_v[PORT_LDR]) begin
                    state_d = req_v[PORT_CPU] ? OWN0 : IDLE;
                end else if (req_v[PORT_CPU] && at_limit) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    dmem_arb_burst_cnt #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_d != state_q),
        .inc      (|beat_v),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= beat_v[PORT_CPU] & ~we0;
            rvalid1_q <= beat_v[PORT_LDR] & ~we1;
            if (beat_v[PORT_CPU] && !we0) begin
                rdata0_q <= mem_rd;
            end
            if (beat_v[PORT_LDR] && !we1) begin
                rdata1_q <= mem_rd;
            end
        end
    end

    assign gnt0     = gnt_v[PORT_CPU];
    assign gnt1     = gnt_v[PORT_LDR];
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign stall0   = req0 & ~gnt_v[PORT_CPU];
    assign mem_we   = (beat_v[PORT_CPU] & we0) | (beat_v[PORT_LDR] & we1);
    assign mem_addr = gnt_v[PORT_LDR] ? addr1 : addr0;
    assign mem_wd   = gnt_v[PORT_LDR] ? wdata1 : wdata0;

endmodule
